// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, operand resolution, load-use stall and ID/EX register.
// Define RV_ID_FWD_EN to enable EX/MEM operand forwarding; otherwise any in-flight producer stalls.
module id_stage #(
    parameter int          RegNum  = 32,
    parameter logic [31:0] PcReset = 32'h0,
    localparam int         AW      = $clog2(RegNum)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          re1,
    output logic          re2,
    output logic [AW-1:0] raddr1,
    output logic [AW-1:0] raddr2,
    input  logic [31:0]   rdata1,
    input  logic [31:0]   rdata2,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_waddr,
    input  logic [31:0]   ex_wdata,
    input  logic          ex_is_load,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [31:0]   mem_wdata,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_op1,
    output logic [31:0]   out_op2,
    output logic [31:0]   out_imm,
    output logic [31:0]   out_rs1,
    output logic [31:0]   out_rs2,
    output logic [AW-1:0] out_waddr,
    output logic          out_we,
    output logic [3:0]    out_alu_op,
    output logic          out_is_load,
    output logic          out_is_store,
    output logic          out_is_branch,
    output logic          out_is_jump,
    output logic          out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {SEL1_RS1, SEL1_PC, SEL1_ZERO} op1_sel_e;
    typedef enum logic [1:0] {SEL2_IMM, SEL2_RS2, SEL2_FOUR} op2_sel_e;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   op1;
        logic [31:0]   op2;
        logic [31:0]   imm;
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [AW-1:0] waddr;
        logic          we;
        logic [3:0]    alu_op;
        logic          is_load;
        logic          is_store;
        logic          is_branch;
        logic          is_jump;
        logic          illegal;
    } payload_t;

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [AW-1:0] rd;
    logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

    logic          use_rs1, use_rs2, we_raw;
    logic          is_load, is_store, is_branch, is_jump, illegal;
    logic [31:0]   imm;
    logic [3:0]    alu_op;
    op1_sel_e      op1_sel;
    op2_sel_e      op2_sel;

    logic [31:0]   rs1_val, rs2_val;
    logic          hazard, adv;
    logic          out_valid_d, out_valid_q;
    payload_t      payload_d, payload_q;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign rd     = in_inst[7 +: AW];
    assign raddr1 = in_inst[15 +: AW];
    assign raddr2 = in_inst[20 +: AW];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        we_raw    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        illegal   = 1'b0;
        imm       = '0;
        alu_op    = '0;
        op1_sel   = SEL1_RS1;
        op2_sel   = SEL2_IMM;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                we_raw  = 1'b1;
                op2_sel = SEL2_RS2;
                alu_op  = {in_inst[30], funct3};
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                we_raw  = 1'b1;
                imm     = imm_i;
                // inst[30] only distinguishes SRAI from SRLI; for other OP-IMM it is immediate data
                alu_op  = (funct3 == 3'b101) ? {in_inst[30], funct3} : {1'b0, funct3};
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                we_raw  = 1'b1;
                is_load = 1'b1;
                imm     = imm_i;
            end
            OPC_STORE: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                is_store = 1'b1;
                imm      = imm_s;
            end
            OPC_BRANCH: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                is_branch = 1'b1;
                imm       = imm_b;
                op2_sel   = SEL2_RS2;
                alu_op    = {1'b0, funct3};
            end
            OPC_JAL: begin
                we_raw  = 1'b1;
                is_jump = 1'b1;
                imm     = imm_j;
                op1_sel = SEL1_PC;
                op2_sel = SEL2_FOUR;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                we_raw  = 1'b1;
                is_jump = 1'b1;
                imm     = imm_i;
                op1_sel = SEL1_PC;
                op2_sel = SEL2_FOUR;
            end
            OPC_LUI: begin
                we_raw  = 1'b1;
                imm     = imm_u;
                op1_sel = SEL1_ZERO;
            end
            OPC_AUIPC: begin
                we_raw  = 1'b1;
                imm     = imm_u;
                op1_sel = SEL1_PC;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign re1 = in_valid && use_rs1;
    assign re2 = in_valid && use_rs2;

    function automatic logic src_hit(input logic en, input logic [AW-1:0] ra,
                                     input logic we, input logic [AW-1:0] wa);
        return en && we && (wa != '0) && (wa == ra);
    endfunction

`ifdef RV_ID_FWD_EN
    function automatic logic [31:0] resolve(input logic [AW-1:0] ra, input logic [31:0] rf_val);
        if (ra == '0)                      return '0;
        else if (ex_we && ex_waddr == ra)   return ex_wdata;
        else if (mem_we && mem_waddr == ra) return mem_wdata;
        else                                return rf_val;
    endfunction

    assign hazard = ex_is_load && (src_hit(re1, raddr1, ex_we, ex_waddr) ||
                                   src_hit(re2, raddr2, ex_we, ex_waddr));
`else
    logic fwd_data_unused;

    function automatic logic [31:0] resolve(input logic [AW-1:0] ra, input logic [31:0] rf_val);
        return (ra == '0) ? '0 : rf_val;
    endfunction

    // Without bypass muxes every in-flight producer of a live source must drain first
    assign hazard = (ex_is_load && (src_hit(re1, raddr1, ex_we, ex_waddr) ||
                                    src_hit(re2, raddr2, ex_we, ex_waddr)))
                 || src_hit(re1, raddr1, ex_we, ex_waddr)  || src_hit(re2, raddr2, ex_we, ex_waddr)
                 || src_hit(re1, raddr1, mem_we, mem_waddr) || src_hit(re2, raddr2, mem_we, mem_waddr);
    assign fwd_data_unused = ^{ex_wdata, mem_wdata};
`endif

    assign rs1_val  = re1 ? resolve(raddr1, rdata1) : '0;
    assign rs2_val  = re2 ? resolve(raddr2, rdata2) : '0;
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = flush || (adv && !hazard);

    always_comb begin
        out_valid_d = out_valid_q;
        payload_d   = payload_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (adv) begin
            out_valid_d         = in_valid && !hazard;
            payload_d.pc        = in_pc;
            payload_d.imm       = imm;
            payload_d.rs1       = rs1_val;
            payload_d.rs2       = rs2_val;
            payload_d.waddr     = rd;
            payload_d.we        = we_raw && !illegal && (rd != '0);
            payload_d.alu_op    = alu_op;
            payload_d.is_load   = is_load;
            payload_d.is_store  = is_store;
            payload_d.is_branch = is_branch;
            payload_d.is_jump   = is_jump;
            payload_d.illegal   = illegal;
            case (op1_sel)
                SEL1_PC:   payload_d.op1 = in_pc;
                SEL1_ZERO: payload_d.op1 = '0;
                default:   payload_d.op1 = rs1_val;
            endcase
            case (op2_sel)
                SEL2_RS2:  payload_d.op2 = rs2_val;
                SEL2_FOUR: payload_d.op2 = 32'd4;
                default:   payload_d.op2 = imm;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            payload_q    <= '0;
            payload_q.pc <= PcReset;
        end else begin
            out_valid_q  <= out_valid_d;
            payload_q    <= payload_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = payload_q.pc;
    assign out_op1       = payload_q.op1;
    assign out_op2       = payload_q.op2;
    assign out_imm       = payload_q.imm;
    assign out_rs1       = payload_q.rs1;
    assign out_rs2       = payload_q.rs2;
    assign out_waddr     = payload_q.waddr;
    assign out_we        = payload_q.we;
    assign out_alu_op    = payload_q.alu_op;
    assign out_is_load   = payload_q.is_load;
    assign out_is_store  = payload_q.is_store;
    assign out_is_branch = payload_q.is_branch;
    assign out_is_jump   = payload_q.is_jump;
    assign out_illegal   = payload_q.illegal;

endmodule
